// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU over one shared add/sub; fixed latency N+3 from start to done.
// No backpressure: start is ignored while busy, flush aborts to IDLE keeping hi/lo/dz.
module muldiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t         state;
  logic [1:0]     op_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   mag;
  logic [2*N:0]   acc;
  logic           sa;
  logic           sb;
  logic           dz_q;
  logic [CW-1:0]  cnt;

  logic           is_div;
  logic           is_sgn;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic [N:0]     add_x;
  logic [N-1:0]   add_y;
  logic           add_sub;
  logic [N+1:0]   add_res;
  logic           borrow;
  logic [2*N:0]   acc_nxt;
  logic [N-1:0]   fix_hi;
  logic [N-1:0]   fix_lo;

  assign is_div = op_q[1];
  assign is_sgn = ~op_q[0];
  assign abs_a  = (is_sgn && a_q[N-1]) ? -a_q : a_q;
  assign abs_b  = (is_sgn && b_q[N-1]) ? -b_q : b_q;

  // Shared datapath: acc high half + multiplicand, or shifted remainder - divisor.
  always_comb begin
    add_sub = is_div;
    if (is_div) begin
      add_x = {acc[2*N-1:N], acc[N-1]};
      add_y = mag;
    end else begin
      add_x = acc[2*N:N];
      add_y = acc[0] ? mag : '0;
    end
    add_res = {1'b0, add_x}
            + (add_sub ? ~{2'b00, add_y} : {2'b00, add_y})
            + {{(N+1){1'b0}}, add_sub};
  end

  assign borrow = add_res[N+1];

  always_comb begin
    if (is_div) begin
      acc_nxt = {1'b0, (borrow ? add_x[N-1:0] : add_res[N-1:0]), acc[N-2:0], ~borrow};
    end else begin
      acc_nxt = {1'b0, add_res[N:0], acc[N-1:1]};
    end
  end

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (dz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (is_div) begin
      fix_lo = (sa ^ sb) ? -acc[N-1:0] : acc[N-1:0];
      fix_hi = sa ? -acc[2*N-1:N] : acc[2*N-1:N];
    end else begin
      {fix_hi, fix_lo} = (sa ^ sb) ? -acc[2*N-1:0] : acc[2*N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mag   <= '0;
      acc   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz_q  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          mag   <= is_div ? abs_b : abs_a;
          acc   <= {{(N+1){1'b0}}, (is_div ? abs_a : abs_b)};
          sa    <= is_sgn & a_q[N-1];
          sb    <= is_sgn & b_q[N-1];
          dz_q  <= is_div && (b_q == '0);
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          acc <= acc_nxt;
          if (cnt == CW'(N-1)) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          dz    <= dz_q;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq against an arithmetic reference with cycle-age timing model.
module tb_muldiv_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         dz;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  int           age = -1;
  logic         e_dz = 1'b0;
  logic [N-1:0] e_hi = '0;
  logic [N-1:0] e_lo = '0;
  logic [2*N:0] pend = '0;

  muldiv_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {dz, hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [2*N:0] ref_op(input logic [1:0] o, input logic [N-1:0] x,
                                          input logic [N-1:0] y);
    longint sx, sy, q, r;
    logic [2*N-1:0] p;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0: begin
        q = sx * sy;
        return {1'b0, q};
      end
      2'd1: begin
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        return {1'b0, p};
      end
      2'd2: begin
        if (y == '0) return {1'b1, x, {N{1'b1}}};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[N-1:0], q[N-1:0]};
      end
      default: begin
        if (y == '0) return {1'b1, x, {N{1'b1}}};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Timing model: age counts cycles since the op was accepted; done at age N+3.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        age = -1; e_dz = 1'b0; e_hi = '0; e_lo = '0;
      end else if (flush) begin
        age = -1;
      end else if ((age == -1 || age == N+3) && start) begin
        age = 1;
        pend = ref_op(op, a, b);
      end else if (age >= 1 && age < N+3) begin
        age++;
        if (age == N+3) {e_dz, e_hi, e_lo} = pend;
      end else begin
        age = -1;
      end
      #1;
      chk("busy", busy, (age >= 1 && age <= N+2));
      chk("done", done, (age == N+3));
      chk("dz", dz, e_dz);
      chk("hi", hi, e_hi);
      chk("lo", lo, e_lo);
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                       input int flush_at, output int lat);
    op = o; a = x; b = y; start = 1'b1; lat = 0;
    for (int i = 1; i <= N+10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (flush_at != 0 && i == flush_at + 1) chk("flush_busy", busy, 1'b0);
      flush = (i == flush_at);
      if (done && lat == 0) lat = i;
      if (flush_at == 0 && done) break;
    end
    flush = 1'b0;
    if (flush_at == 0) chk("latency", lat, N+3);
    else chk("flush_no_done", lat, 0);
  endtask

  task automatic directed(input string nm, input logic [1:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [N-1:0] xh, input logic [N-1:0] xl,
                          input logic xdz);
    int lat;
    do_op(o, x, y, 0, lat);
    chk({nm, "_hi"}, hi, xh);
    chk({nm, "_lo"}, lo, xl);
    chk({nm, "_dz"}, dz, xdz);
  endtask

  initial begin
    logic [2*N:0] r;
    int lat, ndone, sel, gap;
    logic [N-1:0] hs, ls, ra, rb;
    logic [1:0] ro;

    rst_n = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", dz, 1'b0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);

    r = ref_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("model_multu", r, {1'b0, 64'hFFFFFFFE_00000001});
    r = ref_op(2'd0, 32'hFFFFFFFD, 32'h5);
    chk("model_mult", r, {1'b0, 64'hFFFFFFFF_FFFFFFF1});
    r = ref_op(2'd2, 32'hFFFFFFF9, 32'h2);
    chk("model_div", r, {1'b0, 64'hFFFFFFFF_FFFFFFFD});
    r = ref_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("model_divovf", r, {1'b0, 64'h00000000_80000000});
    r = ref_op(2'd3, 32'h1234, 32'h0);
    chk("model_dz", r, {1'b1, 64'h00001234_FFFFFFFF});

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    directed("mult_neg", 2'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    directed("div_neg", 2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    directed("divu", 2'd3, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0);
    directed("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    directed("divu_dz", 2'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1);
    directed("div_dz_neg", 2'd2, 32'hFFFFFF00, 32'h0, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1);
    directed("mult_after_dz", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);

    // Start pulse mid-operation must be ignored.
    op = 2'd0; a = 32'd7; b = 32'd9; start = 1'b1; ndone = 0; lat = 0; hs = '0; ls = '0;
    for (int i = 1; i <= N+8; i++) begin
      @(negedge clk);
      start = (i == 4);
      if (i == 4) begin op = 2'd3; a = 32'd1000; b = 32'd3; end
      if (done) begin
        ndone++;
        if (lat == 0) begin lat = i; hs = hi; ls = lo; end
      end
    end
    start = 1'b0;
    chk("ign_ndone", ndone, 1);
    chk("ign_lat", lat, N+3);
    chk("ign_hi", hs, 32'd0);
    chk("ign_lo", ls, 32'd63);

    // Flush at cycle 10: no done, results held.
    do_op(2'd2, 32'hFFFFFF9C, 32'd7, 10, lat);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'd63);

    // Async reset in the middle of the iterations.
    op = 2'd1; a = 32'hDEADBEEF; b = 32'h12345678; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < N+6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_ndone", ndone, 0);

    // Back-to-back: the second start lands on the done cycle of the first.
    directed("b2b_1", 2'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    directed("b2b_2", 2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    for (int k = 0; k < 60; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) do_op(ro, ra, rb, $urandom_range(2, N+2), lat);
      else do_op(ro, ra, rb, 0, lat);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
